// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: slices the recorded clip in SRAM into overlapping
// FFT frames, streams every frame to the FFT core over valid/ready, waits
// for the core's verdict and writes one beat flag per frame to the beat map.
module fft_frame_sequencer #(
    parameter int FRAME_LEN = 512,
    parameter int HOP       = 256,
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int IDX_W     = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_end_addr,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_rd,
    input  logic              i_sram_valid,
    input  logic [DATA_W-1:0] i_sram_data,
    output logic              o_fft_frame_start,
    output logic [DATA_W-1:0] o_fft_data,
    output logic              o_fft_valid,
    input  logic              i_fft_ready,
    input  logic              i_fft_done,
    input  logic              i_fft_beat,
    output logic              o_beat_wr,
    output logic [IDX_W-1:0]  o_beat_idx,
    output logic              o_beat_val,
    output logic [IDX_W-1:0]  o_frame_cnt,
    output logic              o_busy,
    output logic              o_finish
);

    localparam int               K_W      = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [K_W-1:0]   K_LAST   = K_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] CNT_LAST = CNT_MAX - 1'b1;
    localparam logic [ADDR_W:0]  HOP_EXT  = (ADDR_W + 1)'(HOP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRAME_INIT,
        S_FETCH,
        S_READ_WAIT,
        S_PUSH,
        S_WAIT_FFT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic [ADDR_W:0]     base_q, base_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [IDX_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic                beat_q, beat_d;

    // Sample address and next frame base carry one extra bit so that
    // addresses running past the end of a full-size clip still compare right.
    logic [ADDR_W:0]     addr;
    logic [ADDR_W:0]     next_base;
    logic                addr_in_clip;
    logic                last_frame;
    logic                busy;

    assign addr         = base_q + (ADDR_W + 1)'(k_q);
    assign next_base    = base_q + HOP_EXT;
    assign addr_in_clip = addr < {1'b0, end_q};
    assign last_frame   = next_base >= {1'b0, end_q};
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);

    assign o_busy      = busy;
    assign o_finish    = (state_q == S_DONE);
    assign o_frame_cnt = frame_cnt_q;

    // Next-state, datapath updates and strobe decode.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d           = state_q;
        end_d             = end_q;
        base_d            = base_q;
        k_d               = k_q;
        frame_cnt_d       = frame_cnt_q;
        sample_d          = sample_q;
        beat_d            = beat_q;
        o_sram_addr       = '0;
        o_sram_rd         = 1'b0;
        o_fft_frame_start = 1'b0;
        o_fft_data        = '0;
        o_fft_valid       = 1'b0;
        o_beat_wr         = 1'b0;
        o_beat_idx        = '0;
        o_beat_val        = 1'b0;

        if (busy && !i_start) begin
            // Abort: strobes stay at their defaults, so they drop at once.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        end_d       = i_end_addr;
                        base_d      = '0;
                        k_d         = '0;
                        frame_cnt_d = '0;
                        state_d     = (i_end_addr == '0) ? S_DONE : S_FRAME_INIT;
                    end
                end
                S_FRAME_INIT: begin
                    o_fft_frame_start = 1'b1;
                    k_d               = '0;
                    state_d           = S_FETCH;
                end
                S_FETCH: begin
                    if (addr_in_clip) begin
                        o_sram_rd   = 1'b1;
                        o_sram_addr = addr[ADDR_W-1:0];
                        state_d     = S_READ_WAIT;
                    end else begin
                        sample_d = '0;
                        state_d  = S_PUSH;
                    end
                end
                S_READ_WAIT: begin
                    if (i_sram_valid) begin
                        sample_d = i_sram_data;
                        state_d  = S_PUSH;
                    end
                end
                S_PUSH: begin
                    o_fft_valid = 1'b1;
                    o_fft_data  = sample_q;
                    if (i_fft_ready) begin
                        k_d     = k_q + 1'b1;
                        state_d = (k_q == K_LAST) ? S_WAIT_FFT : S_FETCH;
                    end
                end
                S_WAIT_FFT: begin
                    if (i_fft_done) begin
                        beat_d  = i_fft_beat;
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (frame_cnt_q != CNT_MAX) begin
                        o_beat_wr   = 1'b1;
                        o_beat_idx  = frame_cnt_q;
                        o_beat_val  = beat_q;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                    // A saturated index cannot be written, so stop framing.
                    if (last_frame || frame_cnt_q >= CNT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        base_d  = next_base;
                        state_d = S_FRAME_INIT;
                    end
                end
                S_DONE: begin
                    if (!i_start) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (i_rst) begin
            // NOTE: the datapath registers are reset too (there is no memory
            // array here), so every output reads 0 straight out of reset.
            state_q     <= S_IDLE;
            end_q       <= '0;
            base_q      <= '0;
            k_q         <= '0;
            frame_cnt_q <= '0;
            sample_q    <= '0;
            beat_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            end_q       <= end_d;
            base_q      <= base_d;
            k_q         <= k_d;
            frame_cnt_q <= frame_cnt_d;
            sample_q    <= sample_d;
            beat_q      <= beat_d;
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: SRAM and FFT-core models around the DUT,
// a table of directed runs, randomized runs against a frame-slicing model,
// and hand-written abort / reset / spurious-done sequences.
module tb_fft_frame_sequencer;

    localparam int FRAME_LEN = 8;
    localparam int HOP       = 4;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 16;
    localparam int IDX_W     = 2;
    localparam int CNT_MAX   = (1 << IDX_W) - 1;

    logic              i_clk;
    logic              i_rst;
    logic              i_start;
    logic [ADDR_W-1:0] i_end_addr;
    logic [ADDR_W-1:0] o_sram_addr;
    logic              o_sram_rd;
    logic              i_sram_valid;
    logic [DATA_W-1:0] i_sram_data;
    logic              o_fft_frame_start;
    logic [DATA_W-1:0] o_fft_data;
    logic              o_fft_valid;
    logic              i_fft_ready;
    logic              i_fft_done;
    logic              i_fft_beat;
    logic              o_beat_wr;
    logic [IDX_W-1:0]  o_beat_idx;
    logic              o_beat_val;
    logic [IDX_W-1:0]  o_frame_cnt;
    logic              o_busy;
    logic              o_finish;

    fft_frame_sequencer #(
        .FRAME_LEN (FRAME_LEN),
        .HOP       (HOP),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W)
    ) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_start           (i_start),
        .i_end_addr        (i_end_addr),
        .o_sram_addr       (o_sram_addr),
        .o_sram_rd         (o_sram_rd),
        .i_sram_valid      (i_sram_valid),
        .i_sram_data       (i_sram_data),
        .o_fft_frame_start (o_fft_frame_start),
        .o_fft_data        (o_fft_data),
        .o_fft_valid       (o_fft_valid),
        .i_fft_ready       (i_fft_ready),
        .i_fft_done        (i_fft_done),
        .i_fft_beat        (i_fft_beat),
        .o_beat_wr         (o_beat_wr),
        .o_beat_idx        (o_beat_idx),
        .o_beat_val        (o_beat_val),
        .o_frame_cnt       (o_frame_cnt),
        .o_busy            (o_busy),
        .o_finish          (o_finish)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- SRAM model ----------------
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    int                lat_max = 1;
    bit                sram_pending = 0;
    int                sram_left = 0;
    logic [ADDR_W-1:0] sram_addr_held;
    int                rd_violations = 0;
    logic [ADDR_W-1:0] got_reads [$];

    initial begin
        i_sram_valid = 1'b0;
        i_sram_data  = '0;
        forever begin
            @(negedge i_clk);
            i_sram_valid = 1'b0;
            i_sram_data  = DATA_W'($urandom);
            if (sram_pending) begin
                sram_left--;
                if (sram_left <= 0) begin
                    i_sram_valid = 1'b1;
                    i_sram_data  = mem[sram_addr_held];
                    sram_pending = 0;
                end
            end
            if (o_sram_rd) begin
                if (sram_pending) rd_violations++;
                got_reads.push_back(o_sram_addr);
                sram_pending   = 1;
                sram_left      = int'($urandom_range(1, lat_max));
                sram_addr_held = o_sram_addr;
            end
        end
    end

    // ---------------- FFT core model ----------------
    bit                rand_ready = 0;
    int                stall_at = -1;
    int                stall_left = 0;
    bit                stalled_once = 0;
    int                stall_cycles = 0;
    logic [7:0]        beat_pat = '0;
    int                hs_count = 0;
    int                hs_in_frame = 0;
    int                fft_frame_no = 0;
    int                done_wait = 0;
    int                frame_starts = 0;
    bit                prev_wait = 0;
    logic [DATA_W-1:0] prev_data;
    logic [DATA_W-1:0] got_samples [$];

    initial begin
        i_fft_ready = 1'b0;
        i_fft_done  = 1'b0;
        i_fft_beat  = 1'b0;
        forever begin
            @(negedge i_clk);
            i_fft_done = 1'b0;
            i_fft_beat = 1'($urandom);
            if (done_wait > 0) begin
                done_wait--;
                if (done_wait == 0) begin
                    i_fft_done = 1'b1;
                    i_fft_beat = beat_pat[fft_frame_no % 8];
                    fft_frame_no++;
                end
            end
            if (prev_wait && o_fft_valid)
                check("fft_data_held_under_backpressure", 32'(o_fft_data), 32'(prev_data));
            if (stall_left > 0) begin
                i_fft_ready = 1'b0;
                stall_left--;
            end else if (o_fft_valid && hs_count == stall_at && !stalled_once) begin
                stalled_once = 1;
                stall_left   = 4;
                i_fft_ready  = 1'b0;
            end else begin
                i_fft_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (o_fft_valid && !i_fft_ready) stall_cycles++;
            prev_wait = o_fft_valid && !i_fft_ready;
            prev_data = o_fft_data;
            if (o_fft_frame_start) frame_starts++;
            if (o_fft_valid && i_fft_ready) begin
                got_samples.push_back(o_fft_data);
                hs_count++;
                hs_in_frame++;
                if (hs_in_frame == FRAME_LEN) begin
                    hs_in_frame = 0;
                    done_wait   = int'($urandom_range(1, 4));
                end
            end
        end
    end

    // ---------------- beat-map monitor ----------------
    logic [IDX_W:0] got_beats [$];

    initial begin
        forever begin
            @(negedge i_clk);
            if (o_beat_wr) got_beats.push_back({o_beat_idx, o_beat_val});
        end
    end

    task automatic clear_models();
        got_reads.delete();
        got_samples.delete();
        got_beats.delete();
        sram_pending  = 0;
        sram_left     = 0;
        rd_violations = 0;
        hs_count      = 0;
        hs_in_frame   = 0;
        fft_frame_no  = 0;
        done_wait     = 0;
        stall_left    = 0;
        stalled_once  = 0;
        stall_cycles  = 0;
        frame_starts  = 0;
        prev_wait     = 0;
    endtask

    // ---------------- reference model ----------------
    // Frames cover bases 0, HOP, 2*HOP, ... while base < end, capped by the
    // largest index the beat map can hold.
    function automatic int model_frames(input int e);
        int total;
        total = (e + HOP - 1) / HOP;
        return (total > CNT_MAX) ? CNT_MAX : total;
    endfunction

    function automatic int model_reads(input int e);
        int n;
        n = 0;
        for (int f = 0; f < model_frames(e); f++)
            for (int k = 0; k < FRAME_LEN; k++)
                if (f * HOP + k < e) n++;
        return n;
    endfunction

    task automatic run_seq(input string tag, input int end_a, input int lat, input bit rready,
                           input int stall, input logic [7:0] beats,
                           input int exp_frames, input int exp_reads);
        int                nf;
        int                cyc;
        bit                seen;
        logic [ADDR_W-1:0] exp_rd [$];
        logic [DATA_W-1:0] exp_smp [$];

        clear_models();
        lat_max    = lat;
        rand_ready = rready;
        stall_at   = stall;
        beat_pat   = beats;

        nf = model_frames(end_a);
        for (int f = 0; f < nf; f++) begin
            for (int k = 0; k < FRAME_LEN; k++) begin
                if (f * HOP + k < end_a) begin
                    exp_rd.push_back(ADDR_W'(f * HOP + k));
                    exp_smp.push_back(mem[f * HOP + k]);
                end else begin
                    exp_smp.push_back('0);
                end
            end
        end

        i_end_addr = ADDR_W'(end_a);
        i_start    = 1'b1;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 3000) begin
            @(posedge i_clk);
            #1;
            cyc++;
            if (o_finish) seen = 1;
        end
        check($sformatf("%s_finish_seen", tag), 32'(seen), 32'd1);
        if (end_a == 0) check($sformatf("%s_finish_within_2", tag), 32'(cyc <= 2), 32'd1);
        check($sformatf("%s_frame_cnt", tag), 32'(o_frame_cnt), 32'(exp_frames));
        check($sformatf("%s_busy_in_done", tag), 32'(o_busy), 32'd0);

        i_start = 1'b0;
        @(posedge i_clk);
        #1;
        check($sformatf("%s_finish_clears", tag), 32'(o_finish), 32'd0);
        repeat (10) @(posedge i_clk);
        #1;

        check($sformatf("%s_read_count", tag), 32'(got_reads.size()), 32'(exp_reads));
        for (int i = 0; i < got_reads.size() && i < exp_rd.size(); i++)
            check($sformatf("%s_read_addr_%0d", tag, i), 32'(got_reads[i]), 32'(exp_rd[i]));
        check($sformatf("%s_sample_count", tag), 32'(got_samples.size()), 32'(exp_smp.size()));
        for (int i = 0; i < got_samples.size() && i < exp_smp.size(); i++)
            check($sformatf("%s_sample_%0d", tag, i), 32'(got_samples[i]), 32'(exp_smp[i]));
        check($sformatf("%s_beat_writes", tag), 32'(got_beats.size()), 32'(exp_frames));
        for (int i = 0; i < got_beats.size() && i < nf; i++)
            check($sformatf("%s_beat_%0d", tag, i), 32'(got_beats[i]),
                  32'({IDX_W'(i), beats[i]}));
        check($sformatf("%s_frame_starts", tag), 32'(frame_starts), 32'(exp_frames));
        check($sformatf("%s_rd_while_outstanding", tag), 32'(rd_violations), 32'd0);
        if (stall >= 0 && exp_frames > 0) begin
            if (rready) check($sformatf("%s_stall_seen", tag), 32'(stall_cycles >= 5), 32'd1);
            else        check($sformatf("%s_stall_cycles", tag), 32'(stall_cycles), 32'd5);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'(o_sram_addr) | 32'(o_sram_rd) | 32'(o_fft_frame_start) | 32'(o_fft_data)
             | 32'(o_fft_valid) | 32'(o_beat_wr) | 32'(o_beat_idx) | 32'(o_beat_val)
             | 32'(o_frame_cnt) | 32'(o_busy) | 32'(o_finish);
    endfunction

    typedef struct {
        int         end_a;
        int         lat;
        bit         rready;
        int         stall;
        logic [7:0] beats;
        int         exp_frames;
        int         exp_reads;
    } vec_t;

    vec_t vecs [8];
    int   r_end;
    int   found;

    initial begin
        i_rst      = 1'b1;
        i_start    = 1'b0;
        i_end_addr = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom) | DATA_W'(1);

        // end, latency, random ready, stall sample, beats, frames, reads
        vecs[0] = '{0,  1, 1'b0, -1, 8'b000, 0, 0};
        vecs[1] = '{3,  1, 1'b0, -1, 8'b001, 1, 3};
        vecs[2] = '{10, 3, 1'b0, -1, 8'b101, 3, 16};
        vecs[3] = '{10, 1, 1'b0,  3, 8'b010, 3, 16};
        vecs[4] = '{4,  6, 1'b1, -1, 8'b001, 1, 4};
        vecs[5] = '{5,  2, 1'b1, -1, 8'b010, 2, 6};
        vecs[6] = '{20, 4, 1'b1, -1, 8'b111, 3, 24};
        vecs[7] = '{8,  6, 1'b1, 10, 8'b011, 2, 12};

        repeat (3) @(posedge i_clk);
        #1;
        check("reset_outputs_zero", all_outputs(), 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        check("idle_outputs_zero", all_outputs(), 32'd0);

        for (int v = 0; v < 8; v++)
            run_seq($sformatf("vec%0d", v), vecs[v].end_a, vecs[v].lat, vecs[v].rready,
                    vecs[v].stall, vecs[v].beats, vecs[v].exp_frames, vecs[v].exp_reads);

        for (int r = 0; r < 8; r++) begin
            r_end = int'($urandom_range(0, 24));
            run_seq($sformatf("rnd%0d", r), r_end, int'($urandom_range(1, 6)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1,
                    8'($urandom), model_frames(r_end), model_reads(r_end));
        end

        // Spurious done pulse while idle must not touch the beat map.
        clear_models();
        beat_pat  = 8'hFF;
        done_wait = 2;
        repeat (6) @(posedge i_clk);
        #1;
        check("spurious_done_no_write", 32'(got_beats.size()), 32'd0);
        check("spurious_done_stays_idle", 32'(o_busy), 32'd0);

        // Abort in the middle of the second frame.
        clear_models();
        lat_max    = 2;
        rand_ready = 0;
        stall_at   = -1;
        beat_pat   = 8'b011;
        i_end_addr = ADDR_W'(10);
        i_start    = 1'b1;
        found      = 0;
        for (int c = 0; c < 2000 && found == 0; c++) begin
            @(posedge i_clk);
            #1;
            if (hs_count >= 11 && o_fft_valid) found = 1;
        end
        check("abort_reached_push", 32'(found), 32'd1);
        i_start = 1'b0;
        #1;
        check("abort_valid_drops_at_once", 32'(o_fft_valid), 32'd0);
        check("abort_no_sram_rd", 32'(o_sram_rd), 32'd0);
        @(posedge i_clk);
        #1;
        check("abort_busy_clear", 32'(o_busy), 32'd0);
        check("abort_finish_clear", 32'(o_finish), 32'd0);
        check("abort_frame_cnt_kept", 32'(o_frame_cnt), 32'd1);
        repeat (10) @(posedge i_clk);
        #1;
        check("abort_stays_idle", 32'(o_busy), 32'd0);
        check("abort_beat_writes", 32'(got_beats.size()), 32'd1);

        // Reset while waiting for the FFT result.
        clear_models();
        lat_max    = 1;
        i_end_addr = ADDR_W'(10);
        i_start    = 1'b1;
        found      = 0;
        for (int c = 0; c < 2000 && found == 0; c++) begin
            @(posedge i_clk);
            #1;
            if (hs_count == FRAME_LEN) found = 1;
        end
        check("rst_reached_wait_fft", 32'(found), 32'd1);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        check("rst_in_wait_fft_outputs_zero", all_outputs(), 32'd0);
        i_start = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        repeat (8) @(posedge i_clk);
        #1;
        check("rst_in_wait_fft_no_write", 32'(got_beats.size()), 32'd0);
        check("rst_in_wait_fft_idle", 32'(o_busy), 32'd0);

        run_seq("after_reset", 10, 3, 1'b1, -1, 8'b110, 3, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
